// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing, frame-buffer geometry and palette
// shared by the scan-out datapath and its timing generator.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP
                              + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP
                              + VGA_V_SYNC + VGA_V_BP;

  localparam int ADDR_W = 19;

  typedef logic [2:0]  pix_code_t;
  typedef logic [23:0] rgb_t;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } scan_state_t;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic fs;
  } raster_t;

  localparam raster_t RASTER_IDLE = '{
    active: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0
  };

  // index 0 sits in the low bits: black, white, R, G, B, Y, C, M
  localparam rgb_t [7:0] PALETTE = {
    24'hFF00FF, 24'h00FFFF, 24'hFFFF00, 24'h0000FF,
    24'h00FF00, 24'hFF0000, 24'hFFFFFF, 24'h000000
  };

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: h/v raster counters with enable/idle control.
// Emits undelayed active, syncs and frame-start for the current h/v.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic    clock,
  input  logic    resetn,
  input  logic    enable,
  output raster_t raster,
  output logic    scan
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  scan_state_t     state, state_nx;
  logic [HW-1:0]   h, h_nx;
  logic [VW-1:0]   v, v_nx;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      state <= state_nx;
      h     <= h_nx;
      v     <= v_nx;
    end
  end

  // leaving SCAN is only allowed on the last pixel of a frame
  always_comb begin
    state_nx = state;
    h_nx     = h;
    v_nx     = v;
    unique case (state)
      ST_IDLE: begin
        h_nx = '0;
        v_nx = '0;
        if (enable) state_nx = ST_SCAN;
      end
      ST_SCAN: begin
        if (h == H_LAST) begin
          h_nx = '0;
          v_nx = (v == V_LAST) ? '0 : v + 1'b1;
          if (v == V_LAST && !enable) state_nx = ST_IDLE;
        end else begin
          h_nx = h + 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    scan          = (state == ST_SCAN);
    raster        = RASTER_IDLE;
    raster.active = scan && h < H_ACT && v < V_ACT;
    raster.hs     = !(scan && h >= HS_BEG && h < HS_END);
    raster.vs     = !(scan && v >= VS_BEG && v < VS_END);
    raster.fs     = scan && h == '0 && v == '0;
  end

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: raster-order frame-buffer reader driving VGA pins.
// Address counter, palette lookup and a latency-matched sync delay line.
module fb_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_rden,
  input  pix_code_t         mem_rdata,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic              frame_start
);

  localparam int DEPTH = RD_LATENCY + 2;

  raster_t             raw;
  logic                scan;
  raster_t [DEPTH-1:0] pipe;
  rgb_t                rgb;
  logic [ADDR_W-1:0]   addr_cnt;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clock  (clock),
    .resetn (resetn),
    .enable (enable),
    .raster (raw),
    .scan   (scan)
  );

  // addr_cnt holds the next address; frame start reloads it
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_cnt  <= '0;
      mem_raddr <= '0;
      mem_rden  <= 1'b0;
    end else begin
      mem_rden <= raw.active;
      unique case (1'b1)
        !scan: begin
          addr_cnt  <= '0;
          mem_raddr <= '0;
        end
        raw.fs: begin
          addr_cnt  <= ADDR_W'(1);
          mem_raddr <= '0;
        end
        raw.active && !raw.fs: begin
          addr_cnt  <= addr_cnt + 1'b1;
          mem_raddr <= addr_cnt;
        end
        default: ;
      endcase
    end
  end

  // pipe[RD_LATENCY] lines up with mem_rdata for the same pixel
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pipe <= {DEPTH{RASTER_IDLE}};
      rgb  <= '0;
    end else begin
      pipe <= {pipe[DEPTH-2:0], raw};
      rgb  <= pipe[DEPTH-2].active ? PALETTE[mem_rdata] : '0;
    end
  end

  assign vga_r       = rgb[23:16];
  assign vga_g       = rgb[15:8];
  assign vga_b       = rgb[7:0];
  assign vga_hs      = pipe[DEPTH-1].hs;
  assign vga_vs      = pipe[DEPTH-1].vs;
  assign vga_blank_n = pipe[DEPTH-1].active;
  assign frame_start = pipe[DEPTH-1].fs;

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: randomized checks of fb_scanout against a raster model.
// Full-size timing on one instance, whole-frame behaviour on a tiny one.
module tb_fb_scanout;

  typedef struct packed {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
    int lat;
  } geo_t;

  typedef struct packed {
    logic        rden;
    logic        dc;
    logic [18:0] raddr;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fs;
    logic [23:0] rgb;
  } exp_t;

  localparam geo_t GEO_A = '{ha: 640, hfp: 16, hs: 96, hbp: 48,
                             va: 480, vfp: 10, vs: 2, vbp: 33, lat: 1};
  localparam geo_t GEO_B = '{ha: 16, hfp: 2, hs: 4, hbp: 3,
                             va: 12, vfp: 2, vs: 2, vbp: 3, lat: 2};
  localparam int HT_B = 25;
  localparam int VT_B = 19;
  localparam int FR_B = HT_B * VT_B;
  localparam int D_B  = 4;
  localparam int BIG  = 1 << 30;
  localparam logic [47:0] RST_V = {19'd0, 1'b0, 24'd0, 4'b1100};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn_a = 1'b0, en_a = 1'b0;
  logic [18:0] raddr_a;
  logic        rden_a, hs_a, vs_a, bn_a, fs_a;
  logic [2:0]  rdata_a = 3'd0;
  logic [7:0]  r_a, g_a, b_a;
  logic [23:0] rgb_a;

  logic        resetn_b = 1'b0, en_b = 1'b0;
  logic [18:0] raddr_b;
  logic        rden_b, hs_b, vs_b, bn_b, fs_b;
  logic [2:0]  rdata_b = 3'd0, rd_b1 = 3'd0;
  logic [7:0]  r_b, g_b, b_b;
  logic [23:0] rgb_b;

  int n_pass = 0;
  int n_total = 0;
  int mem_mode = 0;
  int seed = 0;

  assign rgb_a = {r_a, g_a, b_a};
  assign rgb_b = {r_b, g_b, b_b};

  fb_scanout u_a (
    .clock(clock), .resetn(resetn_a), .enable(en_a),
    .mem_raddr(raddr_a), .mem_rden(rden_a), .mem_rdata(rdata_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
    .vga_hs(hs_a), .vga_vs(vs_a), .vga_blank_n(bn_a),
    .frame_start(fs_a)
  );

  fb_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .RD_LATENCY(2)
  ) u_b (
    .clock(clock), .resetn(resetn_b), .enable(en_b),
    .mem_raddr(raddr_b), .mem_rden(rden_b), .mem_rdata(rdata_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .vga_blank_n(bn_b),
    .frame_start(fs_b)
  );

  function automatic int code_of(int addr);
    if (mem_mode == 1) return 7;
    if (addr == 0) return 1;
    if (addr == 1) return 2;
    return ((addr * 13) ^ (addr >> 4) ^ seed) & 7;
  endfunction

  function automatic logic [23:0] pal(int c);
    case (c)
      0: return 24'h000000;
      1: return 24'hFFFFFF;
      2: return 24'hFF0000;
      3: return 24'h00FF00;
      4: return 24'h0000FF;
      5: return 24'hFFFF00;
      6: return 24'h00FFFF;
      default: return 24'hFF00FF;
    endcase
  endfunction

  // RAM models: one and two cycles of read latency
  always @(posedge clock) rdata_a <= 3'(code_of(int'(raddr_a)));
  always @(posedge clock) begin
    rd_b1   <= 3'(code_of(int'(raddr_b)));
    rdata_b <= rd_b1;
  end

  // t: cycles since the counters first showed (0,0); lim: scanned pixels
  function automatic exp_t model(geo_t g, int t, int lim);
    exp_t e;
    int ht, vt, p, h, v;
    bit run;
    ht = g.ha + g.hfp + g.hs + g.hbp;
    vt = g.va + g.vfp + g.vs + g.vbp;
    p = t - 1;
    run = p >= 0 && p < lim;
    h = run ? p % ht : 0;
    v = run ? (p / ht) % vt : 0;
    e.rden = run && h < g.ha && v < g.va;
    e.dc = run && !e.rden;
    e.raddr = e.rden ? 19'(v * g.ha + h) : 19'd0;
    p = t - g.lat - 2;
    run = p >= 0 && p < lim;
    h = run ? p % ht : 0;
    v = run ? (p / ht) % vt : 0;
    e.hs = !(run && h >= g.ha + g.hfp && h < g.ha + g.hfp + g.hs);
    e.vs = !(run && v >= g.va + g.vfp && v < g.va + g.vfp + g.vs);
    e.blank = run && h < g.ha && v < g.va;
    e.fs = run && h == 0 && v == 0;
    e.rgb = e.blank ? pal(code_of(v * g.ha + h)) : 24'h0;
    return e;
  endfunction

  task automatic start_b();
    @(negedge clock);
    resetn_b = 1'b0;
    en_b = 1'b0;
    @(negedge clock);
    resetn_b = 1'b1;
    repeat (2) @(negedge clock);
    en_b = 1'b1;
  endtask

  task automatic test_reset();
    logic [47:0] ga, gb;
    repeat (3) @(negedge clock);
    ga = {raddr_a, rden_a, rgb_a, hs_a, vs_a, bn_a, fs_a};
    gb = {raddr_b, rden_b, rgb_b, hs_b, vs_b, bn_b, fs_b};
    n_total++;
    if (ga !== RST_V) $display("FAIL reset_a got=%h exp=%h", ga, RST_V);
    else n_pass++;
    n_total++;
    if (gb !== RST_V) $display("FAIL reset_b got=%h exp=%h", gb, RST_V);
    else n_pass++;
    resetn_a = 1'b1;
    resetn_b = 1'b1;
    repeat (4) @(negedge clock);
    ga = {raddr_a, rden_a, rgb_a, hs_a, vs_a, bn_a, fs_a};
    gb = {raddr_b, rden_b, rgb_b, hs_b, vs_b, bn_b, fs_b};
    n_total++;
    if (ga !== RST_V) $display("FAIL idle_a got=%h exp=%h", ga, RST_V);
    else n_pass++;
    n_total++;
    if (gb !== RST_V) $display("FAIL idle_b got=%h exp=%h", gb, RST_V);
    else n_pass++;
  endtask

  task automatic test_default_a();
    exp_t e;
    int first_low = -1;
    int hs_low = 0;
    int bn_hi = 0;
    mem_mode = 0;
    @(negedge clock);
    en_a = 1'b1;
    for (int t = 0; t < 2 * 800 + 10; t++) begin
      @(negedge clock);
      e = model(GEO_A, t, BIG);
      n_total++;
      if ({rden_a, e.dc ? 19'd0 : raddr_a, hs_a, vs_a, bn_a, fs_a, rgb_a}
          !== {e.rden, e.raddr, e.hs, e.vs, e.blank, e.fs, e.rgb})
        $display("FAIL full_pins t=%0d got=%b_%h_%b%b%b%b_%h exp=%b_%h_%b%b%b%b_%h",
                 t, rden_a, raddr_a, hs_a, vs_a, bn_a, fs_a, rgb_a,
                 e.rden, e.raddr, e.hs, e.vs, e.blank, e.fs, e.rgb);
      else n_pass++;
      if (t >= 3 && t < 803) begin
        if (first_low < 0 && hs_a === 1'b0) first_low = t;
        hs_low += int'(hs_a === 1'b0);
        bn_hi += int'(bn_a === 1'b1);
      end
      if (t == 3) begin
        n_total++;
        if ({fs_a, rgb_a} !== {1'b1, 24'hFFFFFF})
          $display("FAIL pix00 got=%b_%h exp=1_ffffff", fs_a, rgb_a);
        else n_pass++;
      end
      if (t == 4) begin
        n_total++;
        if (rgb_a !== 24'hFF0000)
          $display("FAIL pix10 got=%h exp=ff0000", rgb_a);
        else n_pass++;
      end
    end
    n_total++;
    if (first_low !== 3 + 656)
      $display("FAIL hs_start got=%0d exp=%0d", first_low, 3 + 656);
    else n_pass++;
    n_total++;
    if (hs_low !== 96) $display("FAIL hs_width got=%0d exp=96", hs_low);
    else n_pass++;
    n_total++;
    if (bn_hi !== 640) $display("FAIL blank_width got=%0d exp=640", bn_hi);
    else n_pass++;
  endtask

  task automatic test_raster_b();
    exp_t e;
    int drop, back;
    int rd_n = 0;
    mem_mode = 0;
    drop = int'($urandom_range(2 * HT_B, FR_B / 2));
    back = drop + int'($urandom_range(1, 20));
    start_b();
    for (int t = 0; t < 2 * FR_B + 6; t++) begin
      @(negedge clock);
      e = model(GEO_B, t, BIG);
      n_total++;
      if ({rden_b, e.dc ? 19'd0 : raddr_b} !== {e.rden, e.raddr})
        $display("FAIL raster t=%0d got=%b_%0d exp=%b_%0d",
                 t, rden_b, raddr_b, e.rden, e.raddr);
      else n_pass++;
      if (t >= 1 && t <= FR_B) rd_n += int'(rden_b === 1'b1);
      en_b = !(t >= drop && t < back);
    end
    n_total++;
    if (rd_n !== 192) $display("FAIL reads_per_frame got=%0d exp=192", rd_n);
    else n_pass++;
  endtask

  task automatic test_sync_b();
    exp_t e;
    int hs_low = 0, vs_low = 0, bn_hi = 0, fs_n = 0;
    start_b();
    for (int t = 0; t < FR_B + D_B + 4; t++) begin
      @(negedge clock);
      e = model(GEO_B, t, BIG);
      n_total++;
      if ({hs_b, vs_b, bn_b, fs_b} !== {e.hs, e.vs, e.blank, e.fs})
        $display("FAIL sync t=%0d got=%b%b%b%b exp=%b%b%b%b", t,
                 hs_b, vs_b, bn_b, fs_b, e.hs, e.vs, e.blank, e.fs);
      else n_pass++;
      if (t >= D_B && t < D_B + FR_B) begin
        hs_low += int'(hs_b === 1'b0);
        vs_low += int'(vs_b === 1'b0);
        bn_hi += int'(bn_b === 1'b1);
        fs_n += int'(fs_b === 1'b1);
      end
    end
    n_total++;
    if ({hs_low, vs_low, bn_hi, fs_n} !== {32'd76, 32'd50, 32'd192, 32'd1})
      $display("FAIL sync_counts got=%0d,%0d,%0d,%0d exp=76,50,192,1",
               hs_low, vs_low, bn_hi, fs_n);
    else n_pass++;
  endtask

  task automatic test_palette_b();
    exp_t e;
    mem_mode = 0;
    start_b();
    for (int t = 0; t < FR_B + D_B + 2; t++) begin
      @(negedge clock);
      e = model(GEO_B, t, BIG);
      n_total++;
      if (rgb_b !== e.rgb)
        $display("FAIL palette t=%0d got=%h exp=%h", t, rgb_b, e.rgb);
      else n_pass++;
      if (t == D_B) begin
        n_total++;
        if ({fs_b, rgb_b} !== {1'b1, 24'hFFFFFF})
          $display("FAIL lat_pix00 got=%b_%h exp=1_ffffff", fs_b, rgb_b);
        else n_pass++;
      end
    end
  endtask

  task automatic test_blank_b();
    exp_t e;
    mem_mode = 1;
    start_b();
    for (int t = 0; t < FR_B + D_B + 2; t++) begin
      @(negedge clock);
      e = model(GEO_B, t, BIG);
      n_total++;
      if ({bn_b, rgb_b} !== {e.blank, e.blank ? 24'hFF00FF : 24'h0})
        $display("FAIL blanking t=%0d got=%b_%h exp=%b", t, bn_b, rgb_b,
                 e.blank);
      else n_pass++;
    end
    mem_mode = 0;
  endtask

  task automatic test_enable_b();
    exp_t e;
    mem_mode = 0;
    start_b();
    for (int t = 0; t < FR_B + 40; t++) begin
      @(negedge clock);
      e = model(GEO_B, t, FR_B);
      n_total++;
      if ({rden_b, e.dc ? 19'd0 : raddr_b, hs_b, vs_b, bn_b, fs_b}
          !== {e.rden, e.raddr, e.hs, e.vs, e.blank, e.fs})
        $display("FAIL en_drop t=%0d got=%b_%0d_%b%b%b%b exp=%b_%0d_%b%b%b%b",
                 t, rden_b, raddr_b, hs_b, vs_b, bn_b, fs_b,
                 e.rden, e.raddr, e.hs, e.vs, e.blank, e.fs);
      else n_pass++;
      if (t == 5 * HT_B) en_b = 1'b0;
    end
    en_b = 1'b1;
    for (int t = 0; t < 3 * HT_B; t++) begin
      @(negedge clock);
      e = model(GEO_B, t, BIG);
      n_total++;
      if ({rden_b, e.dc ? 19'd0 : raddr_b, bn_b, rgb_b}
          !== {e.rden, e.raddr, e.blank, e.rgb})
        $display("FAIL en_restart t=%0d got=%b_%0d_%b_%h exp=%b_%0d_%b_%h",
                 t, rden_b, raddr_b, bn_b, rgb_b,
                 e.rden, e.raddr, e.blank, e.rgb);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_b();
    exp_t e;
    logic [47:0] gb;
    start_b();
    for (int t = 0; t <= 7 * HT_B + 10; t++) @(negedge clock);
    #2 resetn_b = 1'b0;
    #1 gb = {raddr_b, rden_b, rgb_b, hs_b, vs_b, bn_b, fs_b};
    n_total++;
    if (gb !== RST_V) $display("FAIL reset_mid got=%h exp=%h", gb, RST_V);
    else n_pass++;
    @(negedge clock);
    resetn_b = 1'b1;
    for (int t = 0; t < 2 * HT_B; t++) begin
      @(negedge clock);
      e = model(GEO_B, t, BIG);
      n_total++;
      if ({rden_b, e.dc ? 19'd0 : raddr_b, hs_b, bn_b, fs_b, rgb_b}
          !== {e.rden, e.raddr, e.hs, e.blank, e.fs, e.rgb})
        $display("FAIL reset_resume t=%0d got=%b_%0d_%b%b%b_%h exp=%b_%0d_%b%b%b_%h",
                 t, rden_b, raddr_b, hs_b, bn_b, fs_b, rgb_b,
                 e.rden, e.raddr, e.hs, e.blank, e.fs, e.rgb);
      else n_pass++;
    end
  endtask

  initial begin
    seed = int'($urandom_range(0, 7));
    test_reset();
    test_default_a();
    test_raster_b();
    test_sync_b();
    test_palette_b();
    test_blank_b();
    test_enable_b();
    test_reset_mid_b();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
